// File: rtl/single_cycle_arbiter.sv
// -----------------------------------------------------------------------------
// single_cycle_arbiter
//
// N-way fixed-priority arbiter with zero arbitration latency. The lowest-indexed
// active requester wins. The grant, its valid flag and its binary index are all
// combinational from req_i. A single register records the previous cycle's
// grant for debug and pipeline use.
//
// Parameters:
//   N            number of requesters (N >= 1)
//   IW           derived index width, max(1, clog2(N))
//
// Ports:
//   clk          rising-edge clock for the last-grant register
//   reset        asynchronous active-low reset; clears last_gnt_o only
//   req_i        [N]  request vector, bit i = requester i wants the resource
//   gnt_o        [N]  one-hot-or-zero grant, combinational
//   gnt_valid_o        high when any requester is granted (|req_i)
//   gnt_idx_o    [IW] binary index of the granted bit, 0 when no grant
//   last_gnt_o   [N]  gnt_o captured at the previous rising clk edge
//
// Optional build macro:
//   SINGLE_CYCLE_ARBITER_CHECK_EN  compiles concurrent assertions on the
//                                  grant invariants; no functional effect.
// -----------------------------------------------------------------------------
module single_cycle_arbiter #(
  parameter  int N  = 32,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  req_i,
  output logic [N-1:0]  gnt_o,
  output logic          gnt_valid_o,
  output logic [IW-1:0] gnt_idx_o,
  output logic [N-1:0]  last_gnt_o
);

  logic [N-1:0]  w_gnt;
  logic [IW-1:0] w_idx;
  logic          w_found;
  logic [N-1:0]  r_last_gnt;

  // Priority scan from bit 0 upward: the first set request wins and masks
  // every higher index. Reset deliberately plays no part here.
  always_comb begin
    // NOTE: every variable gets a default before the loop so that no path
    // leaves it unassigned, which would otherwise infer a latch.
    w_gnt   = '0;
    w_idx   = '0;
    w_found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (req_i[i] && !w_found) begin
        w_gnt[i] = 1'b1;
        w_idx    = IW'(i);
        w_found  = 1'b1;
      end
    end
  end

  // Previous-cycle grant. Cleared asynchronously and held clear while reset
  // is low; otherwise follows gnt_o one edge behind.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its inputs from before the edge, independent of block order.
    if (!reset) begin
      r_last_gnt <= '0;
    end else begin
      r_last_gnt <= w_gnt;
    end
  end

  assign gnt_o       = w_gnt;
  assign gnt_valid_o = |req_i;
  assign gnt_idx_o   = w_idx;
  assign last_gnt_o  = r_last_gnt;

`ifdef SINGLE_CYCLE_ARBITER_CHECK_EN
  a_gnt_onehot0: assert property (@(posedge clk) disable iff (!reset)
    $onehot0(gnt_o))
    else $error("single_cycle_arbiter: gnt_o not onehot0 at %0t", $time);

  a_gnt_subset_req: assert property (@(posedge clk) disable iff (!reset)
    (gnt_o & ~req_i) == '0)
    else $error("single_cycle_arbiter: grant without request at %0t", $time);

  a_valid_matches_req: assert property (@(posedge clk) disable iff (!reset)
    gnt_valid_o == |req_i)
    else $error("single_cycle_arbiter: gnt_valid_o != |req_i at %0t", $time);

  a_idx_matches_gnt: assert property (@(posedge clk) disable iff (!reset)
    gnt_valid_o |-> (gnt_o == (N'(1) << gnt_idx_o)))
    else $error("single_cycle_arbiter: gnt_idx_o disagrees with gnt_o at %0t", $time);

  a_last_is_past_gnt: assert property (@(posedge clk) disable iff (!reset)
    1'b1 |=> (last_gnt_o == $past(gnt_o)))
    else $error("single_cycle_arbiter: last_gnt_o != past gnt_o at %0t", $time);
`endif

endmodule

// File: tb/tb_single_cycle_arbiter.sv
// -----------------------------------------------------------------------------
// tb_single_cycle_arbiter
//
// Drives a 32-way and a 1-way arbiter. Stimulus pushes the expected response
// into a queue and raises an event; a separate monitor samples the outputs
// 1 ns later (well away from any clock edge) and compares.
// -----------------------------------------------------------------------------
module tb_single_cycle_arbiter;

  localparam int N = 32;

  typedef struct {
    logic [8*16-1:0] name;
    logic            n1;
    logic [N-1:0]    gnt;
    logic            valid;
    logic [4:0]      idx;
    logic [N-1:0]    last;
  } exp_t;

  logic          clk;
  logic          reset;
  logic [N-1:0]  req_i;
  logic [N-1:0]  gnt_o;
  logic          gnt_valid_o;
  logic [4:0]    gnt_idx_o;
  logic [N-1:0]  last_gnt_o;

  logic [0:0]    req1;
  logic [0:0]    gnt1;
  logic          valid1;
  logic [0:0]    idx1;
  logic [0:0]    last1;

  exp_t          sb_q[$];
  event          ev_sample;
  int            n_vec  = 0;
  int            n_miss = 0;

  logic [N-1:0]  m_prev_gnt = '0;
  logic [N-1:0]  m_last     = '0;

  single_cycle_arbiter #(.N(N)) u_dut (
    .clk         (clk),
    .reset       (reset),
    .req_i       (req_i),
    .gnt_o       (gnt_o),
    .gnt_valid_o (gnt_valid_o),
    .gnt_idx_o   (gnt_idx_o),
    .last_gnt_o  (last_gnt_o)
  );

  single_cycle_arbiter #(.N(1)) u_dut_n1 (
    .clk         (clk),
    .reset       (reset),
    .req_i       (req1),
    .gnt_o       (gnt1),
    .gnt_valid_o (valid1),
    .gnt_idx_o   (idx1),
    .last_gnt_o  (last1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: isolate the lowest set bit arithmetically.
  function automatic logic [N-1:0] low_bit(input logic [N-1:0] r);
    return r & (~r + 1'b1);
  endfunction

  function automatic logic [4:0] pos_of(input logic [N-1:0] g);
    logic [4:0] p;
    p = '0;
    for (int k = 0; k < N; k++) if (g[k]) p = 5'(k);
    return p;
  endfunction

  task automatic check(input logic [8*16-1:0] name, input logic [8*8-1:0] field,
                       input logic [N-1:0] act, input logic [N-1:0] req);
    if (act !== req) begin
      n_miss++;
      $display("FAIL %0s.%0s got %h expected %h at %0t", name, field, act, req, $time);
    end
  endtask

  // Monitor: pops one expectation per sample request.
  initial begin
    exp_t e;
    forever begin
      @(ev_sample);
      #1;
      n_vec++;
      if (sb_q.size() == 0) begin
        n_miss++;
        $display("FAIL scoreboard_empty got 0 entries expected 1 at %0t", $time);
      end else begin
        e = sb_q.pop_front();
        if (e.n1) begin
          check(e.name, "gnt",   N'(gnt1),   e.gnt);
          check(e.name, "valid", N'(valid1), N'(e.valid));
          check(e.name, "idx",   N'(idx1),   N'(e.idx));
          check(e.name, "last",  N'(last1),  e.last);
        end else begin
          check(e.name, "gnt",   gnt_o,            e.gnt);
          check(e.name, "valid", N'(gnt_valid_o),  N'(e.valid));
          check(e.name, "idx",   N'(gnt_idx_o),    N'(e.idx));
          check(e.name, "last",  last_gnt_o,       e.last);
        end
      end
    end
  end

  task automatic issue(input logic [8*16-1:0] name, input logic n1,
                       input logic [N-1:0] gnt, input logic valid,
                       input logic [4:0] idx, input logic [N-1:0] last);
    exp_t e;
    e.name = name; e.n1 = n1; e.gnt = gnt; e.valid = valid;
    e.idx = idx; e.last = last;
    sb_q.push_back(e);
    -> ev_sample;
    #2;
  endtask

  // Applies one 32-way vector at a falling edge. Exactly one rising edge has
  // passed since the previous apply, so the model's last-grant is the
  // previous grant when reset is high, otherwise zero.
  task automatic apply(input logic [N-1:0] req, input logic [N-1:0] gnt,
                       input logic [4:0] idx, input logic [8*16-1:0] name);
    @(negedge clk);
    m_last = reset ? m_prev_gnt : '0;
    req_i  = req;
    issue(name, 1'b0, gnt, |req, idx, m_last);
    m_prev_gnt = gnt;
  endtask

  task automatic apply_rand(input logic [N-1:0] req);
    logic [N-1:0] g;
    g = low_bit(req);
    apply(req, g, pos_of(g), "rand");
  endtask

  initial begin
    logic [N-1:0] r;
    reset = 1'b0;
    req_i = '0;
    req1  = '0;

    // Reset held low: combinational grants must still work.
    apply(32'h0000_0000, 32'h0000_0000, 5'd0,  "t1_zero");
    apply(32'hFFFF_FFFF, 32'h0000_0001, 5'd0,  "t2_all");
    apply(32'h8000_0000, 32'h8000_0000, 5'd31, "t3_msb");
    apply(32'h0000_0A00, 32'h0000_0200, 5'd9,  "t3_mid");
    apply(32'h0000_0006, 32'h0000_0002, 5'd1,  "t3_bit1");

    // Single-requester build.
    @(negedge clk); req1 = 1'b1;
    issue("t6_n1_req", 1'b1, 32'd1, 1'b1, 5'd0, 32'd0);
    @(negedge clk); req1 = 1'b0;
    issue("t6_n1_idle", 1'b1, 32'd0, 1'b0, 5'd0, 32'd0);

    // Release reset, capture across an edge, then async clear.
    apply(32'h0000_0030, 32'h0000_0010, 5'd4, "t4_pre");
    reset = 1'b1;
    apply(32'h0000_0030, 32'h0000_0010, 5'd4, "t4_load");
    reset  = 1'b0;
    m_last = '0;
    issue("t4_async_clr", 1'b0, 32'h0000_0010, 1'b1, 5'd4, '0);
    reset = 1'b1;

    // Reset high: random vectors, half of them sparse.
    for (int i = 0; i < 25; i++) begin
      r = $urandom();
      if (i % 2 == 1) r = r & $urandom() & $urandom() & $urandom();
      if (i == 0) r = '0;
      apply_rand(r);
    end
    // Reset low: combinational outputs unaffected, last grant held at zero.
    @(negedge clk); #2;
    reset = 1'b0;
    for (int i = 0; i < 25; i++) begin
      r = $urandom();
      if (i % 2 == 0) r = r & $urandom() & $urandom() & $urandom();
      apply_rand(r);
    end

    #5;
    if (sb_q.size() != 0) begin
      n_miss++;
      $display("FAIL scoreboard_drain got %0d entries expected 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout expected completion at %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
